// File: rtl/gb_lcd_frame_writer.sv
// Palette-mapped pixel sink for the PPU that fills one bank of a double-buffered
// 160x144 frame buffer and hands completed frames to the scanout block.
module gb_lcd_frame_writer #(
   parameter int FB_LINE_PX    = 160,
   parameter int FB_LINES      = 144,
   parameter int FB_BANK_WORDS = 23040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_en,
   input  logic [1:0]  ppu_mode,
   input  logic [7:0]  ly,
   input  logic [7:0]  bgp,
   input  logic [1:0]  px_in,
   input  logic        px_valid,
   input  logic        disp_ready,
   output logic        fb_we,
   output logic [15:0] fb_addr,
   output logic [1:0]  fb_wdata,
   output logic        disp_bank,
   output logic        frame_done,
   output logic [7:0]  frame_drop_cnt,
   output logic        err_line_short,
   output logic        err_px_overflow
);

   localparam logic [1:0] MODE_VBLANK = 2'd1;
   localparam logic [1:0] MODE_DRAW   = 2'd3;

   localparam logic [7:0]  LINE_PX   = 8'(FB_LINE_PX);
   localparam logic [7:0]  LINES     = 8'(FB_LINES);
   localparam logic [15:0] BANK_BASE = 16'(FB_BANK_WORDS);

   logic [1:0]  mode_q;
   logic        wr_bank;
   logic        swap_pending;
   logic [7:0]  col;
   logic [15:0] line_base;
   logic        line_ok;

   logic        draw_edge;
   logic        draw_exit;
   logic        vblank_edge;
   logic        px_take;
   logic        col_in_range;
   logic [1:0]  shade;
   logic [15:0] bank_offset;
   logic [15:0] ly_wide;

   always_comb begin
      draw_edge    = 1'b0;
      draw_exit    = 1'b0;
      vblank_edge  = 1'b0;
      px_take      = 1'b0;
      col_in_range = 1'b0;
      shade        = 2'd0;
      bank_offset  = 16'd0;
      ly_wide      = 16'd0;

      draw_edge    = (ppu_mode == MODE_DRAW)   && (mode_q != MODE_DRAW);
      draw_exit    = (mode_q == MODE_DRAW)     && (ppu_mode != MODE_DRAW);
      vblank_edge  = (ppu_mode == MODE_VBLANK) && (mode_q != MODE_VBLANK);
      px_take      = px_valid && (mode_q == MODE_DRAW) && line_ok;
      col_in_range = (col < LINE_PX);
      shade        = bgp[{px_in, 1'b0} +: 2];
      bank_offset  = wr_bank ? BANK_BASE : 16'd0;
      ly_wide      = {8'd0, ly};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q          <= 2'd0;
         wr_bank         <= 1'b0;
         swap_pending    <= 1'b0;
         col             <= 8'd0;
         line_base       <= 16'd0;
         line_ok         <= 1'b0;
         fb_we           <= 1'b0;
         fb_addr         <= 16'd0;
         fb_wdata        <= 2'd0;
         disp_bank       <= 1'b1;
         frame_done      <= 1'b0;
         frame_drop_cnt  <= 8'd0;
         err_line_short  <= 1'b0;
         err_px_overflow <= 1'b0;
      end else if (!lcd_en) begin
         // LCD off flushes the line and any pending swap; banks, counters and flags hold.
         mode_q       <= 2'd0;
         col          <= 8'd0;
         line_ok      <= 1'b0;
         swap_pending <= 1'b0;
         fb_we        <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         mode_q     <= ppu_mode;
         fb_we      <= 1'b0;
         frame_done <= 1'b0;

         if (draw_edge) begin
            col       <= 8'd0;
            line_base <= (ly_wide << 7) + (ly_wide << 5);
            line_ok   <= (ly < LINES);
         end else if (px_take) begin
            if (col_in_range) begin
               fb_we    <= 1'b1;
               fb_addr  <= bank_offset + line_base + {8'd0, col};
               fb_wdata <= shade;
               col      <= col + 8'd1;
            end else begin
               err_px_overflow <= 1'b1;
            end
         end

         if (draw_exit && line_ok && col_in_range) begin
            err_line_short <= 1'b1;
         end

         // A late disp_ready beats a new frame's first DRAW edge in the same cycle.
         if (vblank_edge) begin
            frame_done <= 1'b1;
            if (disp_ready) begin
               disp_bank <= wr_bank;
               wr_bank   <= ~wr_bank;
            end else begin
               swap_pending <= 1'b1;
            end
         end else if (swap_pending) begin
            if (disp_ready) begin
               disp_bank    <= wr_bank;
               wr_bank      <= ~wr_bank;
               swap_pending <= 1'b0;
            end else if (draw_edge && (ly == 8'd0)) begin
               swap_pending <= 1'b0;
               if (frame_drop_cnt != 8'hFF) begin
                  frame_drop_cnt <= frame_drop_cnt + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gb_lcd_frame_writer.sv
// Scoreboard bench for gb_lcd_frame_writer: expected writes are queued as pixels
// are driven and popped as fb_we appears; bank/flag state is tracked by a small model.
module tb_gb_lcd_frame_writer;

   logic        clk;
   logic        rst;
   logic        lcd_en;
   logic [1:0]  ppu_mode;
   logic [7:0]  ly;
   logic [7:0]  bgp;
   logic [1:0]  px_in;
   logic        px_valid;
   logic        disp_ready;
   logic        fb_we;
   logic [15:0] fb_addr;
   logic [1:0]  fb_wdata;
   logic        disp_bank;
   logic        frame_done;
   logic [7:0]  frame_drop_cnt;
   logic        err_line_short;
   logic        err_px_overflow;

   gb_lcd_frame_writer dut (
      .clk             (clk),
      .rst             (rst),
      .lcd_en          (lcd_en),
      .ppu_mode        (ppu_mode),
      .ly              (ly),
      .bgp             (bgp),
      .px_in           (px_in),
      .px_valid        (px_valid),
      .disp_ready      (disp_ready),
      .fb_we           (fb_we),
      .fb_addr         (fb_addr),
      .fb_wdata        (fb_wdata),
      .disp_bank       (disp_bank),
      .frame_done      (frame_done),
      .frame_drop_cnt  (frame_drop_cnt),
      .err_line_short  (err_line_short),
      .err_px_overflow (err_px_overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] exp_q[$];
   logic [17:0] mon_exp;

   // reference model state
   logic m_wr_bank, m_disp_bank, m_pending, m_line_ok, m_ovf, m_short;
   int   m_drops, m_col, m_ly;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // scoreboard: every write must match the oldest expected write
   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("extra_write", 32'(fb_addr), 32'hFFFF_FFFF);
         end else begin
            mon_exp = exp_q.pop_front();
            check("write", 32'({fb_addr, fb_wdata}), 32'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_wr_bank = 1'b0; m_disp_bank = 1'b1; m_pending = 1'b0; m_line_ok = 1'b0;
      m_ovf = 1'b0; m_short = 1'b0; m_drops = 0; m_col = 0; m_ly = 0;
   endtask

   task automatic model_swap();
      m_disp_bank = m_wr_bank;
      m_wr_bank   = ~m_wr_bank;
      m_pending   = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
      check("rst_disp_bank", 32'(disp_bank), 32'd1);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_drop_cnt", 32'(frame_drop_cnt), 32'd0);
      check("rst_err_short", 32'(err_line_short), 32'd0);
      check("rst_err_ovf", 32'(err_px_overflow), 32'd0);
   endtask

   // driver: DRAW edge for line l
   task automatic start_draw(input int l, input logic dr);
      tick();
      ppu_mode = 2'd3; ly = l[7:0]; px_valid = 1'b0; disp_ready = dr;
      if (m_pending) begin
         if (dr) model_swap();
         else if (l == 0) begin
            if (m_drops < 255) m_drops++;
            m_pending = 1'b0;
         end
      end
      m_col = 0; m_line_ok = (l < 144); m_ly = l;
   endtask

   // driver: one pixel; pat 0 = col%4, else random index
   task automatic drive_px(input int pat, input logic rnd_bgp, output logic wr);
      int p, b, addr;
      tick();
      p = (pat == 0) ? (m_col % 4) : int'($urandom_range(0, 3));
      if (rnd_bgp) bgp = 8'($urandom_range(0, 255));
      px_in = p[1:0]; px_valid = 1'b1;
      b = int'(bgp);
      wr = 1'b0;
      if (m_line_ok) begin
         if (m_col < 160) begin
            addr = (m_wr_bank ? 23040 : 0) + m_ly * 160 + m_col;
            exp_q.push_back({addr[15:0], 2'((b >> (2 * p)) & 3)});
            m_col++;
            wr = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic draw_line(input int l, input int n, input int pat, input logic rnd_bgp,
                            input logic dr, input int off_at);
      logic prev, cur;
      start_draw(l, dr);
      prev = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == off_at) begin
            m_line_ok = 1'b0;
            m_pending = 1'b0;
         end
         drive_px(pat, rnd_bgp, cur);
         if (i >= off_at) lcd_en = 1'b0;
         @(negedge clk);
         check("we_latency", 32'(fb_we), 32'(prev));
         prev = cur;
      end
      tick();
      px_valid = 1'b0; ppu_mode = 2'd0;
      @(negedge clk);
      check("we_latency", 32'(fb_we), 32'(prev));
      if (m_line_ok && m_col < 160) m_short = 1'b1;
      tick();
      lcd_en = 1'b1;
      @(negedge clk);
      check("line_drained", 32'(exp_q.size()), 32'd0);
      check("err_px_overflow", 32'(err_px_overflow), 32'(m_ovf));
      check("err_line_short", 32'(err_line_short), 32'(m_short));
      check("disp_bank", 32'(disp_bank), 32'(m_disp_bank));
      check("frame_drop_cnt", 32'(frame_drop_cnt), 32'(m_drops));
   endtask

   task automatic vblank(input logic dr);
      tick();
      ppu_mode = 2'd1; disp_ready = dr;
      @(negedge clk);
      check("frame_done_pre", 32'(frame_done), 32'd0);
      if (dr) model_swap();
      else m_pending = 1'b1;
      tick();
      @(negedge clk);
      check("frame_done", 32'(frame_done), 32'd1);
      check("vblank_disp_bank", 32'(disp_bank), 32'(m_disp_bank));
      tick();
      @(negedge clk);
      check("frame_done_end", 32'(frame_done), 32'd0);
   endtask

   task automatic raise_ready();
      tick();
      disp_ready = 1'b1;
      @(negedge clk);
      check("pre_swap_bank", 32'(disp_bank), 32'(m_disp_bank));
      model_swap();
      tick();
      @(negedge clk);
      check("delayed_swap_bank", 32'(disp_bank), 32'(m_disp_bank));
   endtask

   initial begin
      logic w;
      rst = 1'b1; lcd_en = 1'b1; ppu_mode = 2'd0; ly = 8'd0; bgp = 8'hE4;
      px_in = 2'd0; px_valid = 1'b0; disp_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();

      // single line, identity palette, col%4 pattern: addresses 800..959
      bgp = 8'hE4;
      draw_line(5, 160, 0, 1'b0, 1'b0, 1000);
      // inverted palette, then per-pixel palette changes
      bgp = 8'h1B;
      draw_line(6, 160, 0, 1'b0, 1'b0, 1000);
      draw_line(7, 160, 1, 1'b1, 1'b0, 1000);
      bgp = 8'hE4;

      // off-screen line: no writes, no flags
      draw_line(150, 160, 1, 1'b0, 1'b0, 1000);
      // overflow, then short line
      draw_line(8, 161, 1, 1'b0, 1'b0, 1000);
      draw_line(9, 150, 1, 1'b0, 1'b0, 1000);

      // full frame then immediate swap; next frame lands in bank 1
      for (int l = 0; l < 144; l++) draw_line(l, 160, 1, 1'b0, 1'b0, 1000);
      vblank(1'b1);
      draw_line(0, 160, 1, 1'b0, 1'b0, 1000);

      // delayed swap
      vblank(1'b0);
      repeat (100) tick();
      @(negedge clk);
      check("pending_bank_hold", 32'(disp_bank), 32'(m_disp_bank));
      raise_ready();
      disp_ready = 1'b0;
      check("delayed_no_drop", 32'(frame_drop_cnt), 32'd0);

      // dropped frame: writes restart in the same bank
      draw_line(0, 160, 1, 1'b0, 1'b0, 1000);
      vblank(1'b0);
      draw_line(0, 160, 1, 1'b0, 1'b0, 1000);
      check("drop_count", 32'(frame_drop_cnt), 32'd1);

      // disp_ready coincides with DRAW edge at ly 0: swap wins
      vblank(1'b0);
      draw_line(0, 16, 1, 1'b0, 1'b1, 1000);
      disp_ready = 1'b0;

      // LCD off mid-line, then a normal line after re-enable
      draw_line(10, 60, 1, 1'b1, 1'b0, 30);
      draw_line(11, 160, 1, 1'b0, 1'b0, 1000);

      // reset mid-line
      start_draw(12, 1'b0);
      for (int i = 0; i < 20; i++) drive_px(1, 1'b0, w);
      tick();
      rst = 1'b1; px_valid = 1'b1;
      tick();
      rst = 1'b0; px_valid = 1'b0; ppu_mode = 2'd0;
      model_reset();
      @(negedge clk);
      check_reset_outputs();
      check("reset_drained", 32'(exp_q.size()), 32'd0);

      repeat (3) tick();
      check("final_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gb_lcd_frame_writer.md
# gb_lcd_frame_writer

Pixel sink for the PPU's background FIFO output. Accepts one 2-bit color index per `px_valid`, maps it through the BGP palette, and writes the resulting shade into a double-buffered 160x144 frame buffer at an address derived from line number and pixel column. Swaps buffers at frame end under a handshake with the display scanout block, so the display always reads a complete frame.

## Interface
- `FB_LINE_PX`, 160: visible pixels per line.
- `FB_LINES`, 144: visible lines per frame.
- `FB_BANK_WORDS`, 23040: words per bank (`FB_LINE_PX*FB_LINES`).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `lcd_en`  in  1  LCDC[7]. Low means idle and flush.
- `ppu_mode`  in  2  0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
- `ly`  in  8  current line from PPU.
- `bgp`  in  8  BG palette register (FF47).
- `px_in`  in  2  color index from PPU shift register.
- `px_valid`  in  1  `px_in` is a pixel this cycle.
- `disp_ready`  in  1  display is in its blanking interval, so a bank swap is allowed.
- `fb_we`  out  1  frame buffer write strobe.
- `fb_addr`  out  16  frame buffer word address. Bank 1 is offset by 23040.
- `fb_wdata`  out  2  shade, 0 = white … 3 = black.
- `disp_bank`  out  1  bank the display must read.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `frame_drop_cnt`  out  8  frames discarded because the swap was refused. Saturates at 255.
- `err_line_short`  out  1  sticky: DRAW ended with column < 160.
- `err_px_overflow`  out  1  sticky: pixel arrived at column ≥ 160.

## Operation
- **Edge detection.** The block registers `ppu_mode` as `mode_q`. The DRAW edge is `ppu_mode==3 && mode_q!=3`, the DRAW-exit edge is `mode_q==3 && ppu_mode!=3`, and the V_BLANK edge is `ppu_mode==1 && mode_q!=1`.
- **DRAW edge.**
  - `col <= 0`.
  - `line_base <= (ly<<7)+(ly<<5)`, i.e. `ly*160`, computed in 16 bits.
  - `line_ok <= (ly < 144)`.
- **Pixel write.** A pixel is one with `px_valid && mode_q==3 && line_ok`.
  - If `col < 160`, the next cycle has `fb_we=1`, `fb_addr = (wr_bank ? 23040 : 0) + line_base + col`, and `fb_wdata = bgp[2*px_in+1 -: 2]`. Then `col++`.
  - If `col == 160`, there is no write, `err_px_overflow <= 1`, and `col` holds.
  - `px_valid` outside DRAW, or with `line_ok==0`, is ignored silently.
- **DRAW exit.** If `line_ok` and `col < 160`, then `err_line_short <= 1`.
- **Frame end** (V_BLANK edge):
  - `frame_done` pulses.
  - If `disp_ready`: swap, so `disp_bank <= wr_bank` and `wr_bank <= ~wr_bank`.
  - Otherwise: `swap_pending <= 1`.
- **Pending swap.** While `swap_pending`:
  - The first cycle with `disp_ready=1` performs the swap and clears `swap_pending`.
  - If a DRAW edge with `ly==0` arrives first, the frame is dropped: `frame_drop_cnt++` (saturating), `swap_pending <= 0`, and `wr_bank` is unchanged, so the next frame overwrites the undisplayed bank.
  - If `disp_ready` and the DRAW edge with `ly==0` occur in the same cycle, the swap wins. The new frame then writes the new `wr_bank`: bank select for the new line is taken after the swap.
- **`lcd_en` low.**
  - `col`, `line_ok`, `swap_pending` and `mode_q` clear, and `fb_we=0`.
  - Banks, counters and error flags hold.
  - On re-enable, the first DRAW edge restarts normally.
- **Reset values.**
  - Outputs: `fb_we=0`, `fb_addr=0`, `fb_wdata=0`, `disp_bank=1`, `frame_done=0`, `frame_drop_cnt=0`, both error flags 0.
  - Internal: `wr_bank=0`, `col=0`, `mode_q=0`, `swap_pending=0`.
- **Reset mid-frame.** Any write in flight is discarded; `fb_we` is 0 on the cycle after `rst`.

## Timing
- `px_valid` to `fb_we`: exactly 1 cycle, with addr and data registered together.
- Back-to-back pixels, one per cycle, give one write per cycle with no stalls. The frame buffer must accept a write every cycle.
- `bgp` is sampled in the same cycle as `px_valid`, so a palette change affects only pixels accepted after it.
- `frame_done` fires 1 cycle after the V_BLANK edge input. `disp_bank` changes on that same cycle when the swap is immediate.
- `disp_bank` never changes while `swap_pending==0` except at a frame-end swap.

## Test plan
- **Single line.** `bgp=0xE4`, DRAW at `ly=5`, 160 pixels with `px_in=col%4`. Expect 160 writes at addresses 800..959, `fb_wdata=col%4`, first `fb_we` 1 cycle after the first `px_valid`, and no error flags.
- **Palette remap.** `bgp=0x1B`, `px_in=0` gives `fb_wdata=3`; `px_in=3` gives `fb_wdata=0`.
- **Immediate swap.** Full frame 0..143 with `disp_ready=1` at the V_BLANK edge. Expect `frame_done` pulse, `disp_bank` 1→0, and next-frame line 0 writing at `fb_addr` 23040.
- **Delayed and dropped swap.** Case 1: `disp_ready=0` at V_BLANK, then high 100 cycles later. Expect the swap on that cycle and `frame_drop_cnt=0`. Case 2: `disp_ready` stays low until the next DRAW with `ly=0`. Expect `frame_drop_cnt=1`, banks unchanged, and writes restarting at 0.
- **Errors.** A line with 161 pixels sets `err_px_overflow` and makes no write at col 160. A line with 150 pixels then DRAW exit sets `err_line_short`. DRAW with `ly=150` and 160 pixels makes no writes and sets no flags.
- **Reset and LCD off.** Assert `rst` mid-line; `fb_we=0` next cycle and all outputs take their reset values. Drop `lcd_en` mid-line; writes stop and banks and counters hold.
